// File: rtl/alorium_lfsr_arb_pkg.sv
// Shared types and constants for the LFSR arbiter/sequencer.
package alorium_lfsr_arb_pkg;

    localparam int STEPS_W  = 3;
    localparam int SEED_W   = 8;
    localparam int NREQ_MAX = 8;
    localparam int PTR_W    = $clog2(NREQ_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Round-robin successor of the owner, wrapping at the configured requester count.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] owner, input int nreq);
        return (int'(owner) == nreq - 1) ? '0 : owner + 1'b1;
    endfunction

endpackage

// File: rtl/alorium_lfsr.sv
// 8-bit XNOR Fibonacci LFSR with synchronous seed load; all-ones is the lock-up state.
module alorium_lfsr #(
    parameter int long_hb = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       new_seed,
    input  logic       enable,
    input  logic [7:0] seed,
    output logic [7:0] lfsr_data
);

    logic feedback;

    assign feedback = (long_hb != 0) ? ~(lfsr_data[7] ^ lfsr_data[6] ^ lfsr_data[4] ^ lfsr_data[3])
                                     : ~(lfsr_data[7] ^ lfsr_data[3]);

    // An all-ones seed would freeze the XNOR sequence, so it is swapped for 0x01.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr_data <= 8'h01;
        end else if (new_seed) begin
            lfsr_data <= (seed == 8'hFF) ? 8'h01 : seed;
        end else if (enable) begin
            lfsr_data <= {lfsr_data[6:0], feedback};
        end
    end

endmodule

// File: rtl/alorium_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr, wrapping modulo NREQ.
module alorium_rr_pick
    import alorium_lfsr_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  onehot,
    output logic [PTR_W-1:0] idx,
    output logic             found
);

    // Outer loop walks priority order; inner loop keeps every bit select constant.
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && req[j] && (j == (int'(ptr) + off) % NREQ)) begin
                    found     = 1'b1;
                    idx       = PTR_W'(j);
                    onehot[j] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alorium_lfsr_arb.sv
// Round-robin arbiter that sequences step/reseed operations on one shared LFSR.
module alorium_lfsr_arb
    import alorium_lfsr_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     arb_en,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_reseed,
    input  logic [NREQ*SEED_W-1:0]   req_seed,
    input  logic [NREQ*STEPS_W-1:0]  req_steps,
    output logic [NREQ-1:0]          grant,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [7:0]               rsp_data,
    output logic                     busy,
    output logic                     lfsr_new_seed,
    output logic                     lfsr_enable,
    output logic [7:0]               lfsr_seed,
    input  logic [7:0]               lfsr_data
);

    arb_state_t         state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner;
    logic               op_reseed;
    logic [STEPS_W-1:0] cnt;

    logic [NREQ-1:0]    pick_onehot;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_found;
    logic               pick_reseed;
    logic [SEED_W-1:0]  pick_seed;
    logic [STEPS_W-1:0] pick_steps;

    alorium_rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    always_comb begin
        pick_reseed = |(req_reseed & pick_onehot);
        pick_seed   = '0;
        pick_steps  = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (pick_onehot[j]) begin
                pick_seed  = req_seed[j*SEED_W +: SEED_W];
                pick_steps = req_steps[j*STEPS_W +: STEPS_W];
            end
        end
    end

    // Outputs are set on the transition into each state so they come straight from flops.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            ptr           <= '0;
            owner         <= '0;
            op_reseed     <= 1'b0;
            cnt           <= '0;
            lfsr_seed     <= '0;
            grant         <= '0;
            rsp_valid     <= '0;
            busy          <= 1'b0;
            lfsr_new_seed <= 1'b0;
            lfsr_enable   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_en && pick_found) begin
                        owner         <= pick_idx;
                        op_reseed     <= pick_reseed;
                        lfsr_seed     <= pick_seed;
                        cnt           <= pick_steps;
                        grant         <= pick_onehot;
                        busy          <= 1'b1;
                        lfsr_new_seed <= pick_reseed;
                        lfsr_enable   <= !pick_reseed;
                        state         <= STEP;
                    end
                end
                STEP: begin
                    if (op_reseed || cnt == '0) begin
                        lfsr_new_seed <= 1'b0;
                        lfsr_enable   <= 1'b0;
                        rsp_valid     <= grant;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    ptr       <= next_ptr(owner, NREQ);
                    grant     <= '0;
                    rsp_valid <= '0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_data = (state == RESP) ? lfsr_data : '0;

endmodule

// File: tb/tb_alorium_lfsr_arb.sv
// Directed bench for alorium_lfsr_arb driving a real alorium_lfsr, with a response scoreboard.
module tb_alorium_lfsr_arb;

    localparam int NREQ = 4;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    logic              clk;
    logic              reset_n;
    logic              arb_en;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   req_reseed;
    logic [NREQ*8-1:0] req_seed;
    logic [NREQ*3-1:0] req_steps;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   rsp_valid;
    logic [7:0]        rsp_data;
    logic              busy;
    logic              lfsr_new_seed;
    logic              lfsr_enable;
    logic [7:0]        lfsr_seed;
    logic [7:0]        lfsr_data;

    int   n_checks  = 0;
    int   n_fail    = 0;
    int   rsp_count = 0;
    exp_t sb[$];
    exp_t mon_e;

    alorium_lfsr_arb #(.NREQ(NREQ)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .arb_en        (arb_en),
        .req           (req),
        .req_reseed    (req_reseed),
        .req_seed      (req_seed),
        .req_steps     (req_steps),
        .grant         (grant),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .busy          (busy),
        .lfsr_new_seed (lfsr_new_seed),
        .lfsr_enable   (lfsr_enable),
        .lfsr_seed     (lfsr_seed),
        .lfsr_data     (lfsr_data)
    );

    alorium_lfsr #(.long_hb(1)) u_lfsr (
        .clk       (clk),
        .reset_n   (reset_n),
        .new_seed  (lfsr_new_seed),
        .enable    (lfsr_enable),
        .seed      (lfsr_seed),
        .lfsr_data (lfsr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_adv(input logic [7:0] x, input int n);
        logic [7:0] v;
        v = x;
        for (int k = 0; k < n; k++) v = {v[6:0], ~(v[7] ^ v[6] ^ v[4] ^ v[3])};
        return v;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset_n    = 1'b0;
        req        = '0;
        req_reseed = '0;
        req_seed   = '0;
        req_steps  = '0;
        cyc(2);
        reset_n = 1'b1;
    endtask

    // One requester runs one op to completion; the response itself is checked by the monitor.
    task automatic applyStimulus(input int idx, input logic reseed, input logic [7:0] seed,
                                 input int steps, input logic [7:0] exp_data);
        int lat, en_cnt, ns_cnt;
        exp_t e;
        req[idx]             = 1'b1;
        req_reseed[idx]      = reseed;
        req_seed[idx*8 +: 8] = seed;
        req_steps[idx*3 +: 3] = 3'(steps);
        e.idx  = idx;
        e.data = exp_data;
        sb.push_back(e);
        lat = 0; en_cnt = 0; ns_cnt = 0;
        while (rsp_valid == '0 && lat < 40) begin
            cyc(1);
            lat++;
            if (lat == 1) checkOutput("grant on first STEP", 32'(grant), 32'(1 << idx));
            if (lfsr_enable) en_cnt++;
            if (lfsr_new_seed) ns_cnt++;
        end
        checkOutput("op latency", 32'(lat), reseed ? 32'd2 : 32'(steps + 2));
        checkOutput("enable cycles", 32'(en_cnt), reseed ? 32'd0 : 32'(steps + 1));
        checkOutput("new_seed cycles", 32'(ns_cnt), reseed ? 32'd1 : 32'd0);
        req[idx] = 1'b0;
        cyc(1);
    endtask

    // Response monitor: pops the scoreboard and watches for enable/new_seed overlap.
    always @(negedge clk) begin
        if (busy) checkOutput("enable/new_seed overlap", 32'(lfsr_enable & lfsr_new_seed), 32'd0);
        if (rsp_valid != '0) begin
            rsp_count++;
            if (sb.size() == 0) begin
                checkOutput("unexpected rsp_valid", 32'(rsp_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("rsp_valid owner", 32'(rsp_valid), 32'(1 << mon_e.idx));
                checkOutput("rsp_data", 32'(rsp_data), 32'(mon_e.data));
            end
        end
    end

    initial begin
        int   rr_steps[NREQ];
        int   order[5];
        int   nresp, gap, guard, saved;
        logic [7:0] x;
        exp_t e;

        arb_en = 1'b1;
        doReset();
        reset_n = 1'b0;
        cyc(1);
        checkOutput("reset grant", 32'(grant), 32'd0);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset new_seed", 32'(lfsr_new_seed), 32'd0);
        checkOutput("reset enable", 32'(lfsr_enable), 32'd0);
        checkOutput("reset lfsr_seed", 32'(lfsr_seed), 32'd0);
        reset_n = 1'b1;

        $display("[TB] single step op, requester 0");
        applyStimulus(0, 1'b0, 8'h00, 0, 8'h03);

        $display("[TB] four-advance step op after reset, requester 1");
        doReset();
        applyStimulus(1, 1'b0, 8'h00, 3, 8'h1E);

        $display("[TB] reseed, step, all-ones reseed on requester 2");
        applyStimulus(2, 1'b1, 8'hA5, 0, 8'hA5);
        applyStimulus(2, 1'b0, 8'h00, 0, 8'h4A);
        applyStimulus(2, 1'b1, 8'hFF, 0, 8'h01);

        $display("[TB] round robin with all requesters active");
        doReset();
        rr_steps = '{1, 0, 2, 3};
        for (int i = 0; i < NREQ; i++) req_steps[i*3 +: 3] = 3'(rr_steps[i]);
        order = '{0, 1, 2, 3, 0};
        x = 8'h01;
        for (int k = 0; k < 5; k++) begin
            x      = lfsr_adv(x, rr_steps[order[k]] + 1);
            e.idx  = order[k];
            e.data = x;
            sb.push_back(e);
        end
        req = 4'b1111;
        nresp = 0; gap = 0; guard = 0;
        while (nresp < 5 && guard < 300) begin
            cyc(1);
            guard++;
            if (rsp_valid != '0) begin
                if (nresp > 0) checkOutput("rr idle gap", 32'(gap), 32'd1);
                gap = 0;
                nresp++;
                if (!(rsp_valid[0] && nresp == 1)) req = req & ~rsp_valid;
            end else if (!busy) begin
                gap++;
            end
        end
        checkOutput("rr response count", 32'(nresp), 32'd5);
        req = '0;
        cyc(1);

        $display("[TB] reset during a long step op");
        req[1]          = 1'b1;
        req_seed[15:8]  = 8'h5A;
        req_steps[5:3]  = 3'd7;
        cyc(3);
        checkOutput("enable in third STEP", 32'(lfsr_enable), 32'd1);
        checkOutput("seed latched", 32'(lfsr_seed), 32'h5A);
        reset_n = 1'b0;
        cyc(1);
        checkOutput("abort grant", 32'(grant), 32'd0);
        checkOutput("abort rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("abort rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort new_seed", 32'(lfsr_new_seed), 32'd0);
        checkOutput("abort enable", 32'(lfsr_enable), 32'd0);
        checkOutput("abort lfsr_seed", 32'(lfsr_seed), 32'd0);
        req        = '0;
        req_seed   = '0;
        req_steps  = '0;
        reset_n    = 1'b1;
        saved      = rsp_count;
        cyc(12);
        checkOutput("no rsp for aborted op", 32'(rsp_count), 32'(saved));

        $display("[TB] arb_en gating");
        arb_en          = 1'b0;
        req[3]          = 1'b1;
        req_steps[11:9] = 3'd2;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            checkOutput("gated busy", 32'(busy), 32'd0);
            checkOutput("gated grant", 32'(grant), 32'd0);
        end
        e.idx  = 3;
        e.data = lfsr_adv(8'h01, 3);
        sb.push_back(e);
        arb_en = 1'b1;
        cyc(1);
        checkOutput("grant after arb_en", 32'(grant), 32'b1000);
        arb_en = 1'b0;
        guard  = 0;
        while (rsp_valid == '0 && guard < 20) begin
            cyc(1);
            guard++;
        end
        checkOutput("op completes with arb_en low", 32'(rsp_valid), 32'b1000);
        req = '0;
        cyc(3);
        checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
